fir_tap_feeder: RTL and testbench

FIR_TAP_FEEDER -- requirements
Module: fir_tap_feeder

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coef_bank.sv | 55 +++++
 rtl/fir_tap_feeder.sv | 132 +++++++++++++
 tb/tb_fir_tap_feeder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap feeder.
// FIR_TAP4_EN selects a 4-tap delay line; otherwise 3 taps.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int NTAPS_3        = 3;
    localparam int NTAPS_4        = 4;
    localparam int DW_DEF         = 8;
    localparam int RESULT_LAT_DEF = 2;

`ifdef FIR_TAP4_EN
    localparam int NTAPS = NTAPS_4;
`else
    localparam int NTAPS = NTAPS_3;
`endif

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks with a deferred commit.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [DW-1:0]       wdata,
    input  logic                commit,
    input  logic                idle,
    input  logic                accept,
    output logic [3:0][DW-1:0]  a
);

    logic [3:0][DW-1:0] shadow_q, shadow_d;
    logic [3:0][DW-1:0] active_q, active_d;
    logic               pending_q, pending_d;
    logic               wr_ok;
    logic               do_copy;

    assign wr_ok = int'(addr) < NTAPS;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q | commit;
        do_copy   = idle && !accept && pending_d;
        // Copy reads the registered shadow, so a same-cycle write lands later.
        if (do_copy) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (we && wr_ok) begin
            shadow_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign a = active_q;

endmodule

// File: rtl/fir_tap_feeder.sv
// Delay line and start/latency FSM feeding a FIR MAC stage.
// FIR_TAP4_EN enables the fourth tap (X3/A3).
module fir_tap_feeder
    import fir_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int RESULT_LAT = RESULT_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          c_we,
    input  logic [1:0]    c_addr,
    input  logic [DW-1:0] c_data,
    input  logic          c_commit,
    output logic [DW-1:0] X0,
    output logic [DW-1:0] X1,
    output logic [DW-1:0] X2,
    output logic [DW-1:0] X3,
    output logic [DW-1:0] A0,
    output logic [DW-1:0] A1,
    output logic [DW-1:0] A2,
    output logic [DW-1:0] A3,
    output logic          enable,
    output logic          result_valid,
    output logic          primed
);

    localparam int CW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0][DW-1:0] x_q, x_d;
    logic [2:0]         fill_q, fill_d;
    logic               s_ready_q, s_ready_d;
    logic               enable_q, enable_d;
    logic               rv_q, rv_d;
    logic               accept;
    logic [3:0][DW-1:0] a;

    assign accept = (state_q == IDLE) && s_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    x_d[0] = s_data;
                    x_d[1] = x_q[0];
                    x_d[2] = x_q[1];
`ifdef FIR_TAP4_EN
                    x_d[3] = x_q[2];
`else
                    x_d[3] = '0;
`endif
                    if (fill_q < 3'(NTAPS)) begin
                        fill_d = fill_q + 3'd1;
                    end
                    state_d = FIRE;
                end
            end
            FIRE: begin
                cnt_d   = CW'(RESULT_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next-state decode.
        s_ready_d = (state_d == IDLE);
        enable_d  = (state_d == FIRE);
        rv_d      = (state_d == WAIT) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            fill_q    <= '0;
            s_ready_q <= 1'b1;
            enable_q  <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            fill_q    <= fill_d;
            s_ready_q <= s_ready_d;
            enable_q  <= enable_d;
            rv_q      <= rv_d;
        end
    end

    fir_coef_bank #(.DW(DW)) u_coef (
        .clk    (clk),
        .rst    (rst),
        .we     (c_we),
        .addr   (c_addr),
        .wdata  (c_data),
        .commit (c_commit),
        .idle   (state_q == IDLE),
        .accept (accept),
        .a      (a)
    );

    assign s_ready      = s_ready_q;
    assign enable       = enable_q;
    assign result_valid = rv_q;
    assign primed       = (fill_q == 3'(NTAPS));

    assign X0 = x_q[0];
    assign X1 = x_q[1];
    assign X2 = x_q[2];
    assign X3 = x_q[3];
    assign A0 = a[0];
    assign A1 = a[1];
    assign A2 = a[2];
    assign A3 = a[3];

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed self-checking bench for fir_tap_feeder (default DW=8, RESULT_LAT=2).
module tb_fir_tap_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       c_we;
    logic [1:0] c_addr;
    logic [7:0] c_data;
    logic       c_commit;
    logic [7:0] X0, X1, X2, X3;
    logic [7:0] A0, A1, A2, A3;
    logic       enable;
    logic       result_valid;
    logic       primed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_tap_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .c_we         (c_we),
        .c_addr       (c_addr),
        .c_data       (c_data),
        .c_commit     (c_commit),
        .X0           (X0),
        .X1           (X1),
        .X2           (X2),
        .X3           (X3),
        .A0           (A0),
        .A1           (A1),
        .A2           (A2),
        .A3           (A3),
        .enable       (enable),
        .result_valid (result_valid),
        .primed       (primed)
    );

`ifdef FIR_TAP4_EN
    localparam bit TAP4 = 1'b1;
`else
    localparam bit TAP4 = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one sample and walk the FIRE/WAIT/WAIT/IDLE sequence.
    task automatic feed(input logic [7:0] d);
        chk("ready_before", {31'd0, s_ready}, 32'd1);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("fire_en", {31'd0, enable}, 32'd1);
        chk("fire_rdy", {31'd0, s_ready}, 32'd0);
        chk("fire_x0", {24'd0, X0}, {24'd0, d});
        tick();
        chk("wait1_en", {31'd0, enable}, 32'd0);
        chk("wait1_rdy", {31'd0, s_ready}, 32'd0);
        chk("wait1_rv", {31'd0, result_valid}, 32'd0);
        tick();
        chk("wait0_rv", {31'd0, result_valid}, 32'd1);
        chk("wait0_rdy", {31'd0, s_ready}, 32'd0);
        tick();
        chk("idle_rv", {31'd0, result_valid}, 32'd0);
        chk("idle_rdy", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic wr(input logic [1:0] ad, input logic [7:0] v);
        c_we   = 1'b1;
        c_addr = ad;
        c_data = v;
        tick();
        c_we   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, {X0, X1, X2, X3}, 32'd0);
        chk({tag, "_a"}, {A0, A1, A2, A3}, 32'd0);
        chk({tag, "_flags"}, {29'd0, enable, result_valid, primed}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        s_data   = '0;
        s_valid  = 1'b0;
        c_we     = 1'b0;
        c_addr   = '0;
        c_data   = '0;
        c_commit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_zero("reset");
        chk("reset_rdy", {31'd0, s_ready}, 32'd1);

        // Fill the delay line.
        feed(8'd1);
        chk("primed_1", {31'd0, primed}, 32'd0);
        feed(8'd2);
        chk("primed_2", {31'd0, primed}, 32'd0);
        feed(8'd3);
        chk("primed_3", {31'd0, primed}, {31'd0, !TAP4});
        chk("x_3", {X0, X1, X2, X3}, 32'h03020100);
        feed(8'd4);
        chk("primed_4", {31'd0, primed}, 32'd1);
        chk("x_4", {X0, X1, X2, X3}, TAP4 ? 32'h04030201 : 32'h04030200);

        // Shadow writes, then commit in IDLE.
        wr(2'd0, 8'd5);
        wr(2'd1, 8'd6);
        wr(2'd2, 8'd7);
        wr(2'd3, 8'd8);
        chk("a_before_commit", {A0, A1, A2, A3}, 32'd0);
        c_commit = 1'b1;
        tick();
        c_commit = 1'b0;
        chk("a_commit", {A0, A1, A2, A3}, TAP4 ? 32'h05060708 : 32'h05060700);

        // Commit raised during WAIT is deferred to the next IDLE cycle.
        wr(2'd0, 8'h21);
        s_data  = 8'h10;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("w_fire_a0", {24'd0, A0}, 32'h05);
        tick();
        c_commit = 1'b1;
        tick();
        c_commit = 1'b0;
        chk("w_rv", {31'd0, result_valid}, 32'd1);
        chk("w_rv_a0", {24'd0, A0}, 32'h05);
        tick();
        chk("w_idle_a0", {24'd0, A0}, 32'h05);
        tick();
        chk("w_after_a0", {24'd0, A0}, 32'h21);

        // Sample and commit in the same IDLE cycle: sample wins.
        wr(2'd1, 8'h33);
        s_data   = 8'h11;
        s_valid  = 1'b1;
        c_commit = 1'b1;
        tick();
        s_valid  = 1'b0;
        c_commit = 1'b0;
        chk("s_fire_x0", {24'd0, X0}, 32'h11);
        chk("s_fire_a1", {24'd0, A1}, 32'h06);
        tick();
        tick();
        chk("s_rv_a1", {24'd0, A1}, 32'h06);
        tick();
        chk("s_idle_a1", {24'd0, A1}, 32'h06);
        tick();
        chk("s_after_a1", {24'd0, A1}, 32'h33);

        // Write and copy together: copy takes the old shadow value.
        c_we     = 1'b1;
        c_addr   = 2'd2;
        c_data   = 8'h44;
        c_commit = 1'b1;
        tick();
        c_we     = 1'b0;
        c_commit = 1'b0;
        chk("wc_a2_old", {24'd0, A2}, 32'h07);
        c_commit = 1'b1;
        tick();
        c_commit = 1'b0;
        chk("wc_a2_new", {24'd0, A2}, 32'h44);

        // Index 3 write only lands in the 4-tap build.
        wr(2'd3, 8'd9);
        c_commit = 1'b1;
        tick();
        c_commit = 1'b0;
        chk("a3_write", {24'd0, A3}, TAP4 ? 32'd9 : 32'd0);

        // Reset in WAIT aborts without a result strobe.
        s_data  = 8'h55;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("abort_wait_rv", {31'd0, result_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk_zero("abort_async");
        tick();
        rst = 1'b0;
        chk("abort_rdy", {31'd0, s_ready}, 32'd1);
        tick();
        chk("abort_rv1", {31'd0, result_valid}, 32'd0);
        tick();
        chk("abort_rv2", {31'd0, result_valid}, 32'd0);
        chk_zero("abort_idle");

        // Refill after reset.
        feed(8'hA1);
        feed(8'hA2);
        chk("refill_p2", {31'd0, primed}, 32'd0);
        feed(8'hA3);
        chk("refill_p3", {31'd0, primed}, {31'd0, !TAP4});
        chk("refill_x3", {24'd0, X3}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
